// File: rtl/counter_pins_pkg.sv
// Shared op codes, FSM encoding and sizing helpers
// for the counter pin driver.
package counter_pins_pkg;

    localparam logic [1:0] OP_DISABLE = 2'b00;
    localparam logic [1:0] OP_ENABLE  = 2'b01;
    localparam logic [1:0] OP_LOAD    = 2'b10;
    localparam logic [1:0] OP_STEP    = 2'b11;

    // The counter double-syncs its pins and then
    // edge-detects, so each level must last 3 clocks.
    localparam int MIN_HOLD = 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_EN_WAIT,
        ST_DIS_WAIT,
        ST_SETUP,
        ST_PULSE_HI,
        ST_PULSE_LO,
        ST_FINISH
    } state_e;

    // Timer must hold 2*hold-1 (the enable wait).
    function automatic int timer_width(input int hold);
        return $clog2(2 * hold);
    endfunction

endpackage

// File: rtl/pin_phase_timer.sv
// Phase timer: loads a count, ticks down to 0, holds.
// Ports: clk, rst, load, load_val, tick -> zero.
module pin_phase_timer #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         tick,
    output logic         zero
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (tick && count_q != '0) begin
            count_d = count_q - W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero = (count_q == '0);

endmodule

// File: rtl/counter_pin_driver.sv
// Host-command to counter-pin waveform driver with a
// shadow of the counter value.
// Ports: clk/rst; cmd_valid/ready/op/dir/data in;
// done/err status; enable/clk_in/load/up_down/data
// pins; expected_o shadow counter value.
module counter_pin_driver
    import counter_pins_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int HOLD_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic              cmd_dir,
    input  logic [DATA_W-1:0] cmd_data,
    output logic              done,
    output logic              err,
    output logic              enable_o,
    output logic              clk_in_o,
    output logic              load_o,
    output logic              up_down_o,
    output logic [DATA_W-1:0] data_o,
    output logic [DATA_W-1:0] expected_o
);

    localparam int TW = timer_width(HOLD_CYCLES);
    localparam logic [TW-1:0] HOLD_M1 =
        TW'(HOLD_CYCLES - 1);
    localparam logic [TW-1:0] HOLD2_M1 =
        TW'(2 * HOLD_CYCLES - 1);

    if (HOLD_CYCLES < MIN_HOLD) begin : g_bad_hold
        $error("HOLD_CYCLES below MIN_HOLD");
    end

    state_e            state_q, state_d;
    logic [1:0]        op_q, op_d;
    logic [DATA_W-1:0] n_q, n_d;
    logic              ready_q, ready_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              enable_q, enable_d;
    logic              clk_in_q, clk_in_d;
    logic              load_q, load_d;
    logic              up_down_q, up_down_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [DATA_W-1:0] expected_q, expected_d;

    logic              tmr_load;
    logic [TW-1:0]     tmr_val;
    logic              tmr_zero;
    logic              tmr_tick;
    logic [DATA_W-1:0] step_val;

    assign tmr_tick = (state_q != ST_IDLE);

    pin_phase_timer #(
        .W(TW)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .load    (tmr_load),
        .load_val(tmr_val),
        .tick    (tmr_tick),
        .zero    (tmr_zero)
    );

    // Shadow follows the direction pin, wrapping.
    assign step_val = up_down_q ?
        expected_q + DATA_W'(1) :
        expected_q - DATA_W'(1);

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        n_d        = n_q;
        ready_d    = ready_q;
        err_d      = 1'b0;
        enable_d   = enable_q;
        clk_in_d   = clk_in_q;
        load_d     = load_q;
        up_down_d  = up_down_q;
        data_d     = data_q;
        expected_d = expected_q;
        tmr_load   = 1'b0;
        tmr_val    = HOLD_M1;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid && ready_q) begin
                    ready_d = 1'b0;
                    op_d    = cmd_op;
                    // No-op and error commands finish
                    // immediately unless overridden.
                    state_d = ST_FINISH;
                    case (cmd_op)
                        OP_ENABLE: begin
                            if (!enable_q) begin
                                enable_d = 1'b1;
                                state_d  = ST_EN_WAIT;
                                tmr_load = 1'b1;
                                tmr_val  = HOLD2_M1;
                            end
                        end
                        OP_DISABLE: begin
                            if (enable_q) begin
                                enable_d = 1'b0;
                                state_d  = ST_DIS_WAIT;
                                tmr_load = 1'b1;
                            end
                        end
                        default: begin
                            if (!enable_q) begin
                                err_d = 1'b1;
                            end else begin
                                state_d  = ST_SETUP;
                                tmr_load = 1'b1;
                                if (cmd_op == OP_LOAD) begin
                                    data_d = cmd_data;
                                end else begin
                                    up_down_d = cmd_dir;
                                    n_d       = cmd_data;
                                end
                            end
                        end
                    endcase
                end
            end
            ST_EN_WAIT: begin
                if (tmr_zero) begin
                    state_d = ST_FINISH;
                    // Counter clears on enable rise.
                    expected_d = '0;
                end
            end
            ST_DIS_WAIT: begin
                if (tmr_zero) begin
                    state_d = ST_FINISH;
                end
            end
            ST_SETUP: begin
                if (tmr_zero) begin
                    if (op_q == OP_LOAD) begin
                        state_d    = ST_PULSE_HI;
                        load_d     = 1'b1;
                        expected_d = data_q;
                        tmr_load   = 1'b1;
                    end else if (n_q == '0) begin
                        state_d = ST_FINISH;
                    end else begin
                        state_d    = ST_PULSE_HI;
                        clk_in_d   = 1'b1;
                        expected_d = step_val;
                        n_d        = n_q - DATA_W'(1);
                        tmr_load   = 1'b1;
                    end
                end
            end
            ST_PULSE_HI: begin
                if (tmr_zero) begin
                    state_d  = ST_PULSE_LO;
                    load_d   = 1'b0;
                    clk_in_d = 1'b0;
                    tmr_load = 1'b1;
                end
            end
            ST_PULSE_LO: begin
                if (tmr_zero) begin
                    if (op_q == OP_LOAD || n_q == '0) begin
                        state_d = ST_FINISH;
                    end else begin
                        state_d    = ST_PULSE_HI;
                        clk_in_d   = 1'b1;
                        expected_d = step_val;
                        n_d        = n_q - DATA_W'(1);
                        tmr_load   = 1'b1;
                    end
                end
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
                ready_d = 1'b1;
            end
            default: begin
                state_d  = ST_IDLE;
                ready_d  = 1'b1;
                clk_in_d = 1'b0;
                load_d   = 1'b0;
            end
        endcase

        done_d = (state_d == ST_FINISH);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            op_q       <= OP_DISABLE;
            n_q        <= '0;
            ready_q    <= 1'b1;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            enable_q   <= 1'b0;
            clk_in_q   <= 1'b0;
            load_q     <= 1'b0;
            up_down_q  <= 1'b0;
            data_q     <= '0;
            expected_q <= '0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            n_q        <= n_d;
            ready_q    <= ready_d;
            done_q     <= done_d;
            err_q      <= err_d;
            enable_q   <= enable_d;
            clk_in_q   <= clk_in_d;
            load_q     <= load_d;
            up_down_q  <= up_down_d;
            data_q     <= data_d;
            expected_q <= expected_d;
        end
    end

    assign cmd_ready  = ready_q;
    assign done       = done_q;
    assign err        = err_q;
    assign enable_o   = enable_q;
    assign clk_in_o   = clk_in_q;
    assign load_o     = load_q;
    assign up_down_o  = up_down_q;
    assign data_o     = data_q;
    assign expected_o = expected_q;

endmodule
